// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state enum and bus payload structs for alu_core / alu_arb.
package alu_pkg;

   localparam int unsigned DW_C  = 32;
   localparam int unsigned OP_W  = 5;
   localparam int unsigned SH_W  = 5;
   localparam int unsigned LANES = 2;

   localparam logic [OP_W-1:0] OP_NOP   = 5'b00000;
   localparam logic [OP_W-1:0] OP_LUI   = 5'b00001;
   localparam logic [OP_W-1:0] OP_AUIPC = 5'b00010;
   localparam logic [OP_W-1:0] OP_ADD   = 5'b00011;
   localparam logic [OP_W-1:0] OP_SUB   = 5'b00100;
   localparam logic [OP_W-1:0] OP_SLL   = 5'b01000;
   localparam logic [OP_W-1:0] OP_SRL   = 5'b01100;
   localparam logic [OP_W-1:0] OP_SRA   = 5'b11000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Captured request: operands, opcode and owning requester
   typedef struct packed {
      logic [DW_C-1:0] a;
      logic [DW_C-1:0] b;
      logic [OP_W-1:0] op;
      logic            id;
   } req_t;

   typedef struct packed {
      logic [DW_C-1:0] c;
      logic            zero;
      logic            id;
   } resp_t;

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU; unlisted opcodes produce zero so no prior result leaks through.
module alu_core
   import alu_pkg::*;
(
   input  logic [DW_C-1:0] A,
   input  logic [DW_C-1:0] B,
   input  logic [OP_W-1:0] op,
   output logic [DW_C-1:0] C,
   output logic            zero
);

   logic [SH_W-1:0] w_shamt;

   assign w_shamt = B[SH_W-1:0];

   always_comb begin
      C = '0;
      case (op)
         OP_NOP:           C = '0;
         OP_LUI, OP_AUIPC: C = B;
         OP_ADD:           C = A + B;
         OP_SUB:           C = A - B;
         OP_SLL:           C = A << w_shamt;
         OP_SRL:           C = A >> w_shamt;
         OP_SRA:           C = DW_C'($signed(A) >>> w_shamt);
         default:          C = '0;
      endcase
   end

   assign zero = (C == '0);

endmodule

// File: rtl/alu_arb.sv
// Two-requester ALU front end: arbitrate, capture, execute for one cycle, hold response until taken.
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority (lane 0 first).
module alu_arb
   import alu_pkg::*;
#(
   parameter int unsigned DW = 32
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [LANES-1:0]     req_valid,
   output logic [LANES-1:0]     req_ready,
   input  logic [2*DW-1:0]      req_a,
   input  logic [2*DW-1:0]      req_b,
   input  logic [2*OP_W-1:0]    req_op,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic                 resp_id,
   output logic [DW-1:0]        resp_c,
   output logic                 resp_zero
);

   state_t           r_state;
   state_t           w_state_nxt;
   req_t             r_req;
   req_t             w_req_sel;
   resp_t            r_resp;
   logic             r_resp_valid;
   logic             w_gnt_id;
   logic             w_accept;
   logic [LANES-1:0] w_req_ready;
   logic [DW_C-1:0]  w_alu_c;
   logic             w_alu_zero;

`ifdef ALU_ARB_RR_EN
   // Pointer names the lane that wins a tie; it flips away from whoever was just granted
   logic r_ptr;

   always_comb begin
      w_gnt_id = 1'b0;
      if (&req_valid) begin
         w_gnt_id = r_ptr;
      end else begin
         w_gnt_id = req_valid[1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= 1'b0;
      end else if (w_accept) begin
         r_ptr <= ~w_gnt_id;
      end
   end
`else
   assign w_gnt_id = ~req_valid[0];
`endif

   // Operands of whichever lane wins this cycle
   always_comb begin
      w_req_sel    = '0;
      w_req_sel.a  = w_gnt_id ? req_a[2*DW-1:DW] : req_a[DW-1:0];
      w_req_sel.b  = w_gnt_id ? req_b[2*DW-1:DW] : req_b[DW-1:0];
      w_req_sel.op = w_gnt_id ? req_op[2*OP_W-1:OP_W] : req_op[OP_W-1:0];
      w_req_sel.id = w_gnt_id;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state; grant is only offered from IDLE and never while reset is held
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_req_ready = '0;
      case (r_state)
         IDLE: begin
            if (!rst && (|req_valid)) begin
               w_accept    = 1'b1;
               w_req_ready = w_gnt_id ? 2'b10 : 2'b01;
               w_state_nxt = EXEC;
            end
         end
         EXEC:    w_state_nxt = RESP;
         RESP: begin
            if (resp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   alu_core u_alu (
      .A    (r_req.a),
      .B    (r_req.b),
      .op   (r_req.op),
      .C    (w_alu_c),
      .zero (w_alu_zero)
   );

   // Capture on grant, latch ALU result in EXEC, drop valid once the consumer takes it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_req        <= '0;
         r_resp       <= '0;
         r_resp_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_req <= w_req_sel;
         end
         if (r_state == EXEC) begin
            r_resp.c     <= w_alu_c;
            r_resp.zero  <= w_alu_zero;
            r_resp.id    <= r_req.id;
            r_resp_valid <= 1'b1;
         end else if ((r_state == RESP) && resp_ready) begin
            r_resp_valid <= 1'b0;
         end
      end
   end

   assign req_ready  = w_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_id    = r_resp.id;
   assign resp_c     = r_resp.c;
   assign resp_zero  = r_resp.zero;

endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb: transaction-level reference model checked every cycle plus literal expectations.
module tb_alu_arb;

   localparam logic [4:0] T_NOP   = 5'b00000;
   localparam logic [4:0] T_LUI   = 5'b00001;
   localparam logic [4:0] T_AUIPC = 5'b00010;
   localparam logic [4:0] T_ADD   = 5'b00011;
   localparam logic [4:0] T_SUB   = 5'b00100;
   localparam logic [4:0] T_SLL   = 5'b01000;
   localparam logic [4:0] T_SRL   = 5'b01100;
   localparam logic [4:0] T_SRA   = 5'b11000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_ready;
   logic [63:0] req_a = '0;
   logic [63:0] req_b = '0;
   logic [9:0]  req_op = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic        resp_id;
   logic [31:0] resp_c;
   logic        resp_zero;

   int total = 0;
   int bad   = 0;
   int cyc_p = 0;

   alu_arb #(.DW(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_c     (resp_c),
      .resp_zero  (resp_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_p <= cyc_p + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      total++;
      bad++;
      $display("FAIL %s: timed out waiting for DUT", nm);
   endtask

   // Reference ALU straight from the opcode table
   function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      int unsigned sh;
      sh = b % 32;
      case (op)
         T_LUI, T_AUIPC: return b;
         T_ADD:          return a + b;
         T_SUB:          return a - b;
         T_SLL:          return a << sh;
         T_SRL:          return a >> sh;
         T_SRA:          return 32'($signed(a) >>> sh);
         default:        return 32'd0;
      endcase
   endfunction

   // Transaction-level model: one outstanding op, response visible two cycles after acceptance
   bit          m_known = 1'b0;
   bit          m_busy  = 1'b0;
   int          m_acc   = 0;
   bit          m_last  = 1'b1;
   logic        m_rid;
   logic [31:0] m_res;
   logic [1:0]  e_rdy;
   bit          e_vld;
   logic        e_g;

   function automatic logic pick(input logic [1:0] v);
`ifdef ALU_ARB_RR_EN
      if (v == 2'b11) return ~m_last;
      return v[1];
`else
      if (v[0]) return 1'b0;
      return 1'b1;
`endif
   endfunction

   always @(negedge clk) begin
      e_vld = m_busy && (cyc_p >= m_acc + 2);
      e_rdy = 2'b00;
      e_g   = 1'b0;
      if (!rst && !m_busy && (req_valid != 2'b00)) begin
         e_g   = pick(req_valid);
         e_rdy = e_g ? 2'b10 : 2'b01;
      end
      if (m_known) begin
         chk("mon_rdy", 32'(req_ready), 32'(e_rdy));
         chk("mon_vld", 32'(resp_valid), 32'(e_vld));
         if (e_vld) begin
            chk("mon_c", resp_c, m_res);
            chk("mon_zero", 32'(resp_zero), 32'(m_res == 32'd0));
            chk("mon_id", 32'(resp_id), 32'(m_rid));
         end
      end
      if (rst) begin
         m_known = 1'b1;
         m_busy  = 1'b0;
         m_last  = 1'b1;
      end else if (e_vld && resp_ready) begin
         m_busy = 1'b0;
      end else if (e_rdy != 2'b00) begin
         m_busy = 1'b1;
         m_acc  = cyc_p;
         m_rid  = e_g;
         m_last = e_g;
         m_res  = e_g ? ref_alu(req_op[9:5], req_a[63:32], req_b[63:32])
                      : ref_alu(req_op[4:0], req_a[31:0], req_b[31:0]);
      end
   end

   task automatic issue(input int lane, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int acc);
      bit got;
      got = 1'b0;
      acc = -100;
      @(posedge clk); #1;
      req_a[lane*32 +: 32] = a;
      req_b[lane*32 +: 32] = b;
      req_op[lane*5 +: 5]  = op;
      req_valid[lane]      = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (req_ready[lane]) begin
            got = 1'b1;
            acc = cyc_p;
            break;
         end
      end
      if (!got) fail_now("accept");
      @(posedge clk); #1;
      req_valid[lane] = 1'b0;
   endtask

   task automatic wait_resp(input int acc, input string nm, input logic [31:0] exp_c, input logic exp_id);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         fail_now({nm, "_resp"});
      end else begin
         chk({nm, "_lat"}, 32'(cyc_p - acc), 32'd2);
         chk({nm, "_c"}, resp_c, exp_c);
         chk({nm, "_zero"}, 32'(resp_zero), 32'(exp_c == 32'd0));
         chk({nm, "_id"}, 32'(resp_id), 32'(exp_id));
      end
   endtask

   task automatic do_op(input int lane, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_c, input string nm);
      int acc;
      issue(lane, op, a, b, acc);
      wait_resp(acc, nm, exp_c, 1'(lane));
   endtask

   logic [4:0]  t_op [10] = '{T_LUI, T_AUIPC, T_ADD, T_SUB, T_SLL, T_SRL, T_SRA, T_NOP, 5'b00101, 5'b11111};
   logic [31:0] t_a  [10] = '{32'h1, 32'h100, 32'hFFFF_FFFF, 32'd3, 32'h1, 32'h8000_0000,
                             32'h7FFF_FFF0, 32'd5, 32'hFFFF_FFFF, 32'h1234};
   logic [31:0] t_b  [10] = '{32'h1234_5000, 32'hABC, 32'd2, 32'd5, 32'h21, 32'd31,
                             32'd4, 32'd5, 32'd1, 32'h1234};
   logic [31:0] t_c  [10] = '{32'h1234_5000, 32'hABC, 32'h1, 32'hFFFF_FFFE, 32'h2, 32'h1,
                             32'h07FF_FFFF, 32'h0, 32'h0, 32'h0};

   initial begin
      int acc;
      int cnt;
      int n;
      bit got;
      logic g_seen [4];
      logic g_exp  [4];

      // Reset and idle state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_vld", 32'(resp_valid), 32'd0);
      chk("reset_rdy", 32'(req_ready), 32'd0);
      chk("reset_c", resp_c, 32'd0);
      chk("reset_zero", 32'(resp_zero), 32'd0);
      chk("reset_id", 32'(resp_id), 32'd0);

      do_op(0, T_ADD, 32'd5, 32'd7, 32'd12, "add0");
      do_op(1, T_SUB, 32'd9, 32'd9, 32'd0, "sub1");
      do_op(1, T_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, "sra1");
      for (int i = 0; i < 10; i++) begin
         do_op(i % 2, t_op[i], t_a[i], t_b[i], t_c[i], $sformatf("tbl%0d", i));
      end

      // Consumer stalls while the other lane waits
      @(posedge clk); #1 resp_ready = 1'b0;
      issue(0, T_SRL, 32'hF000_0000, 32'd4, acc);
      req_a[63:32] = 32'd3;
      req_b[63:32] = 32'd2;
      req_op[9:5]  = T_SLL;
      req_valid[1] = 1'b1;
      wait_resp(acc, "stall", 32'h0F00_0000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_vld", 32'(resp_valid), 32'd1);
         chk("stall_c", resp_c, 32'h0F00_0000);
         chk("stall_rdy", 32'(req_ready), 32'd0);
      end
      @(posedge clk); #1 resp_ready = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready[1]) begin
            got = 1'b1;
            acc = cyc_p;
            break;
         end
      end
      if (!got) fail_now("post_stall_accept");
      @(posedge clk); #1 req_valid[1] = 1'b0;
      wait_resp(acc, "post_stall", 32'd12, 1'b1);

      // Reset while lane 0 is executing: the op must vanish
      issue(0, T_ADD, 32'd1, 32'd1, acc);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (resp_valid) cnt++;
      end
      chk("rst_noresp", 32'(cnt), 32'd0);
      do_op(1, T_ADD, 32'h10, 32'h20, 32'h30, "post_rst");

      // Both lanes held valid across reset, then contending continuously
      @(posedge clk); #1;
      rst       = 1'b1;
      req_a     = {32'd20, 32'd10};
      req_b     = {32'd2, 32'd1};
      req_op    = {T_ADD, T_ADD};
      req_valid = 2'b11;
      @(negedge clk);
      chk("rst_rdy_a", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("rst_rdy_b", 32'(req_ready), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
`ifdef ALU_ARB_RR_EN
      g_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      g_exp = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      n = 0;
      for (int i = 0; (i < 40) && (n < 4); i++) begin
         @(negedge clk);
         if (req_ready != 2'b00) begin
            g_seen[n] = req_ready[1];
            n++;
         end
      end
      @(posedge clk); #1 req_valid = 2'b00;
      if (n < 4) begin
         fail_now("grant_seq");
      end else begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("grant%0d", i), 32'(g_seen[i]), 32'(g_exp[i]));
         end
      end

      repeat (6) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
